mpsoc_msi_wb_rr_arbiter: RTL and testbench
==========================================

# mpsoc_msi_wb_rr_arbiter

Round-robin Wishbone arbiter sharing one wide slave (e.g. the upsizer's downstream memory port) among NUM_MASTERS bus masters. It holds each grant for the whole bus cycle, so classic and burst (cti/bte) transfers are never split. A per-transfer watchdog terminates hung slave accesses with an error to the owning master.

## Interface
- NUM_MASTERS, 4: requesting masters, 2..16
- AW, 32: address width
- DW, 64: data width, multiple of 8
- TIMEOUT, 255: cycles without slave termination before abort; 0 disables the watchdog

Per-master buses are flat vectors, master i in slice [i*W +: W].
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbm_adr_i  in  NUM_MASTERS*AW  master addresses
- wbm_dat_i  in  NUM_MASTERS*DW  master write data
- wbm_sel_i  in  NUM_MASTERS*DW/8  byte selects
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS each  control
- wbm_cti_i  in  NUM_MASTERS*3;  wbm_bte_i  in  NUM_MASTERS*2  burst tags
- wbm_dat_o  out  DW  slave read data, broadcast to all masters
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS each  per-master termination
- wbs_adr_o/dat_o/sel_o/we_o/cti_o/bte_o  out  AW/DW/DW/8/1/3/2  muxed from owner
- wbs_cyc_o, wbs_stb_o  out  1  slave cycle/strobe
- wbs_dat_i  in  DW;  wbs_ack_i, wbs_err_i, wbs_rty_i  in  1  slave response
- grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle

## Operation
- State registers: gnt_vld, gnt_idx, rr_ptr, abort, wd_cnt.
- IDLE (gnt_vld=0): if any wbm_cyc_i high, select first index with cyc high searching rr_ptr, rr_ptr+1, … modulo NUM_MASTERS; next cycle gnt_vld=1, gnt_idx=selected, rr_ptr=selected+1 (wraps to 0).
- OWNED (gnt_vld=1): stay while wbm_cyc_i[gnt_idx]=1. When it is 0, next cycle gnt_vld=0, abort=0, back to IDLE. There is no same-cycle handover; at least one idle cycle separates owners.
- Slave mux: address/data/sel/we/cti/bte from master gnt_idx. wbs_cyc_o = gnt_vld & cyc[gnt_idx] & ~abort. wbs_stb_o = wbs_cyc_o & stb[gnt_idx].
- Responses: ack/err/rty routed combinationally to bit gnt_idx only; all other bits 0. Slave responses are ignored when wbs_cyc_o=0.
- Watchdog (TIMEOUT>0): wd_cnt clears when wbs_stb_o=0 or any slave termination occurs. It increments while wbs_stb_o=1 with no termination. On the cycle wd_cnt==TIMEOUT-1 and still no termination: wbm_err_o[gnt_idx]=1 for that single cycle, and abort=1 from the next cycle. While abort=1, wbs_cyc_o=wbs_stb_o=0 and all terminations to the master are 0, until the owner drops cyc.
- Widths: wd_cnt is $clog2(TIMEOUT+1) bits. gnt_idx and rr_ptr are $clog2(NUM_MASTERS) bits; the pointer wraps explicitly at NUM_MASTERS-1.

## Timing
- Reset: gnt_vld=0, gnt_idx=0, rr_ptr=0, abort=0, wd_cnt=0. Hence wbs_cyc_o=wbs_stb_o=0, grant_o=0, all wbm_ack/err/rty_o=0. Reset mid-cycle drops wbs_cyc_o on the next edge.
- Grant latency: cyc rises at edge N, wbs_cyc_o is high after edge N+1.
- Response path is combinational; zero added latency per beat.
- Owner deasserts cyc at edge M: wbs_cyc_o low immediately (combinational), grant_o=0 after edge M+1, new grant after M+2 at the earliest.
- Simultaneous requests: pointer order decides. A master re-requesting right after release gets priority only after all others with cyc high.
- Owner cyc drop in the same cycle as watchdog expiry: the err pulse is still issued, and the arbiter returns to IDLE normally.

## Test plan
- Single master 0 writes 0x1122334455667788 at 0x40, then reads it back → grant_o=0001 one cycle after cyc, read data matches, other ack bits stay 0.
- Masters 0..3 raise cyc together, each doing one transfer → grant order 0,1,2,3 and rr_ptr=0 afterwards, one idle cycle between grants.
- Master 1 issues an 8-beat incrementing burst (cti=010, bte=00) while master 2 requests → all 8 acks go to master 1; master 2 is granted only after master 1 drops cyc.
- Slave held never acking, TIMEOUT=16 → exactly one err pulse to the owner, 16 cycles after stb; wbs_cyc_o=0 afterwards until the master drops cyc; next request is served normally.
- Assert wb_rst_i during an active burst → next edge wbs_cyc_o=0, grant_o=0, rr_ptr=0; after release, master 0 wins a four-way contention.

Source files
------------

// File: rtl/mpsoc_msi_wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one wide slave shared by NUM_MASTERS masters,
// grant held for the whole bus cycle, with a per-transfer hang watchdog.
module mpsoc_msi_wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 64,
    parameter int TIMEOUT     = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
    output logic [DW-1:0]             wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS-1:0]    wbm_rty_o,
    output logic [AW-1:0]             wbs_adr_o,
    output logic [DW-1:0]             wbs_dat_o,
    output logic [DW/8-1:0]           wbs_sel_o,
    output logic                      wbs_we_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    input  logic [DW-1:0]             wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_MASTERS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [WW-1:0] WD_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WW-1:0] WD_ONE   = WW'(1);

    logic          gnt_vld_q, gnt_vld_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IW-1:0] rr_ptr_q,  rr_ptr_d;
    logic          abort_q,   abort_d;
    logic [WW-1:0] wd_cnt_q,  wd_cnt_d;

    logic          own_cyc_s, own_stb_s, slv_cyc_s, slv_stb_s;
    logic          term_s, wd_fire_s;
    logic          sel_found_s;
    logic [IW-1:0] sel_idx_s;

    // Owner selection and slave-side mux from the current owner's slice.
    always_comb begin
        own_cyc_s = wbm_cyc_i[gnt_idx_q];
        own_stb_s = wbm_stb_i[gnt_idx_q];
        slv_cyc_s = gnt_vld_q & own_cyc_s & ~abort_q;
        slv_stb_s = slv_cyc_s & own_stb_s;
        wbs_cyc_o = slv_cyc_s;
        wbs_stb_o = slv_stb_s;
        wbs_adr_o = wbm_adr_i[int'(gnt_idx_q)*AW +: AW];
        wbs_dat_o = wbm_dat_i[int'(gnt_idx_q)*DW +: DW];
        wbs_sel_o = wbm_sel_i[int'(gnt_idx_q)*(DW/8) +: DW/8];
        wbs_we_o  = wbm_we_i[gnt_idx_q];
        wbs_cti_o = wbm_cti_i[int'(gnt_idx_q)*3 +: 3];
        wbs_bte_o = wbm_bte_i[int'(gnt_idx_q)*2 +: 2];
        wbm_dat_o = wbs_dat_i;
    end

    // Watchdog expiry: the last counted stb cycle still lacking a termination.
    always_comb begin
        term_s = slv_cyc_s & (wbs_ack_i | wbs_err_i | wbs_rty_i);
        if (TIMEOUT > 0) begin
            wd_fire_s = slv_stb_s & ~term_s & (wd_cnt_q == WD_LAST);
        end else begin
            wd_fire_s = 1'b0;
        end
    end

    // Terminations steered to the owner only; watchdog error merged in.
    always_comb begin
        wbm_ack_o = {NUM_MASTERS{1'b0}};
        wbm_err_o = {NUM_MASTERS{1'b0}};
        wbm_rty_o = {NUM_MASTERS{1'b0}};
        grant_o   = {NUM_MASTERS{1'b0}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_idx_q == IW'(i)) begin
                wbm_ack_o[i] = slv_cyc_s & wbs_ack_i;
                wbm_err_o[i] = (slv_cyc_s & wbs_err_i) | wd_fire_s;
                wbm_rty_o[i] = slv_cyc_s & wbs_rty_i;
                grant_o[i]   = gnt_vld_q;
            end else begin
                grant_o[i]   = 1'b0;
            end
        end
    end

    // Round-robin search: reverse scan so the closest index to rr_ptr wins.
    always_comb begin
        int k;
        k           = 0;
        sel_found_s = 1'b0;
        sel_idx_s   = {IW{1'b0}};
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            k = int'(rr_ptr_q) + i;
            if (k >= NUM_MASTERS) begin
                k = k - NUM_MASTERS;
            end else begin
                k = k;
            end
            if (wbm_cyc_i[k]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IW'(k);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Next-state for grant ownership, pointer, abort and watchdog counter.
    always_comb begin
        gnt_vld_d = gnt_vld_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        abort_d   = abort_q;
        if (!gnt_vld_q) begin
            abort_d = 1'b0;
            if (sel_found_s) begin
                gnt_vld_d = 1'b1;
                gnt_idx_d = sel_idx_s;
                rr_ptr_d  = (sel_idx_s == IDX_LAST) ? {IW{1'b0}} : sel_idx_s + IDX_ONE;
            end else begin
                gnt_vld_d = 1'b0;
            end
        end else if (!own_cyc_s) begin
            gnt_vld_d = 1'b0;
            abort_d   = 1'b0;
        end else if (wd_fire_s) begin
            abort_d   = 1'b1;
        end else begin
            abort_d   = abort_q;
        end

        if ((TIMEOUT == 0) || !slv_stb_s || term_s || wd_fire_s) begin
            wd_cnt_d = {WW{1'b0}};
        end else begin
            wd_cnt_d = wd_cnt_q + WD_ONE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            gnt_vld_q <= 1'b0;
            gnt_idx_q <= {IW{1'b0}};
            rr_ptr_q  <= {IW{1'b0}};
            abort_q   <= 1'b0;
            wd_cnt_q  <= {WW{1'b0}};
        end else begin
            gnt_vld_q <= gnt_vld_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            abort_q   <= abort_d;
            wd_cnt_q  <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_mpsoc_msi_wb_rr_arbiter.sv
// Scoreboard bench for the round-robin Wishbone arbiter: expected grants and
// terminations are queued by the stimulus and popped by a negedge monitor.
module tb_mpsoc_msi_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            wb_rst_i;
    logic [N*AW-1:0] wbm_adr_i;
    logic [N*DW-1:0] wbm_dat_i;
    logic [N*DW/8-1:0] wbm_sel_i;
    logic [N-1:0]    wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [N*3-1:0]  wbm_cti_i;
    logic [N*2-1:0]  wbm_bte_i;
    logic [DW-1:0]   wbm_dat_o;
    logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0]   wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o;
    logic [DW/8-1:0] wbs_sel_o;
    logic            wbs_we_o;
    logic [2:0]      wbs_cti_o;
    logic [1:0]      wbs_bte_o;
    logic            wbs_cyc_o, wbs_stb_o;
    logic [DW-1:0]   wbs_dat_i;
    logic            wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic [N-1:0]    grant_o;

    logic [AW-1:0]   m_adr [N];
    logic [DW-1:0]   m_dat [N];
    logic [N-1:0]    m_we, m_cyc, m_stb;
    logic [2:0]      m_cti [N];
    logic            slave_en;
    logic [DW-1:0]   mem [16];

    typedef struct {
        int          m;
        bit          is_err;
        bit          chk_dat;
        logic [63:0] dat;
    } resp_t;

    resp_t resp_q[$];
    int    grant_q[$];
    int    checks   = 0;
    int    failures = 0;

    mpsoc_msi_wb_rr_arbiter #(
        .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    // Pack per-master stimulus into the flat DUT vectors.
    always_comb begin
        wbm_adr_i = '0;
        wbm_dat_i = '0;
        wbm_sel_i = '1;
        wbm_cti_i = '0;
        wbm_bte_i = '0;
        wbm_we_i  = m_we;
        wbm_cyc_i = m_cyc;
        wbm_stb_i = m_stb;
        for (int i = 0; i < N; i++) begin
            wbm_adr_i[i*AW +: AW] = m_adr[i];
            wbm_dat_i[i*DW +: DW] = m_dat[i];
            wbm_cti_i[i*3 +: 3]   = m_cti[i];
        end
    end

    // Zero-wait memory slave; slave_en=0 models a hung slave.
    assign wbs_dat_i = mem[wbs_adr_o[6:3]];
    assign wbs_ack_i = wbs_stb_o & slave_en;
    assign wbs_err_i = 1'b0;
    assign wbs_rty_i = 1'b0;

    always @(posedge clk) begin
        if (wbs_ack_i && wbs_we_o) mem[wbs_adr_o[6:3]] <= wbs_dat_o;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic exp_grant(input int m);
        grant_q.push_back(m);
    endtask

    task automatic exp_resp(input int m, input bit is_err, input bit chk_dat, input logic [63:0] dat);
        resp_t r;
        r.m = m; r.is_err = is_err; r.chk_dat = chk_dat; r.dat = dat;
        resp_q.push_back(r);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One master transaction of nbeats; burst beats tagged with cti, last 111.
    task automatic master_do(input int m, input logic [31:0] adr, input logic [63:0] dat,
                             input logic we, input int nbeats, input logic [2:0] cti);
        bit got;
        m_cyc[m] = 1'b1;
        m_we[m]  = we;
        for (int b = 0; b < nbeats; b++) begin
            m_stb[m] = 1'b1;
            m_adr[m] = adr + 32'(b * 8);
            m_dat[m] = dat + 64'(b);
            m_cti[m] = (nbeats == 1) ? 3'b000 : ((b == nbeats - 1) ? 3'b111 : cti);
            got = 1'b0;
            for (int t = 0; t < 64; t++) begin
                @(negedge clk);
                if (wbm_ack_o[m] | wbm_err_o[m]) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout master=%0d beat=%0d actual=no_term required=term", m, b);
            end
            @(posedge clk);
            #1;
        end
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        m_cti[m] = 3'b000;
    endtask

    task automatic reset_dut();
        wb_rst_i = 1'b1;
        idle(3);
        wb_rst_i = 1'b0;
    endtask

    // Monitor: new grants and every termination are checked against the queues.
    initial begin
        logic [N-1:0] prev_grant;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (grant_o != '0 && grant_o != prev_grant) begin
                chk("idle_gap_before_grant", 64'(prev_grant), 64'd0);
                if (grant_q.size() == 0) begin
                    chk("unexpected_grant", 64'(grant_o), 64'd0);
                end else begin
                    int g;
                    g = grant_q.pop_front();
                    chk("grant_owner", 64'(grant_o), 64'(1 << g));
                end
            end
            prev_grant = grant_o;
            if ((wbm_ack_o | wbm_err_o | wbm_rty_o) != '0) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_term", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'd0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("resp_ack", 64'(wbm_ack_o), r.is_err ? 64'd0 : 64'(1 << r.m));
                    chk("resp_err", 64'(wbm_err_o), r.is_err ? 64'(1 << r.m) : 64'd0);
                    chk("resp_rty", 64'(wbm_rty_o), 64'd0);
                    if (r.chk_dat) chk("read_data", wbm_dat_o, r.dat);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        bit got;
        for (int i = 0; i < N; i++) begin
            m_adr[i] = '0; m_dat[i] = '0; m_cti[i] = 3'b000;
        end
        for (int i = 0; i < 16; i++) mem[i] = '0;
        m_we = '0; m_cyc = '0; m_stb = '0;
        slave_en = 1'b1;
        wb_rst_i = 1'b1;

        // Reset state.
        reset_dut();
        @(negedge clk);
        chk("rst_wbs_cyc", 64'(wbs_cyc_o), 64'd0);
        chk("rst_wbs_stb", 64'(wbs_stb_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_ack", 64'(wbm_ack_o), 64'd0);
        chk("rst_err", 64'(wbm_err_o), 64'd0);
        chk("rst_rty", 64'(wbm_rty_o), 64'd0);
        @(posedge clk);
        #1;

        // Single master write then read-back, with grant latency.
        exp_grant(0);
        exp_resp(0, 1'b0, 1'b0, 64'd0);
        fork
            master_do(0, 32'h40, 64'h1122334455667788, 1'b1, 1, 3'b000);
            begin
                @(negedge clk);
                chk("a_grant_before", 64'(grant_o), 64'd0);
                @(negedge clk);
                chk("a_grant_latency", 64'(grant_o), 64'h1);
            end
        join
        idle(2);
        exp_grant(0);
        exp_resp(0, 1'b0, 1'b1, 64'h1122334455667788);
        master_do(0, 32'h40, 64'd0, 1'b0, 1, 3'b000);
        idle(2);

        // Four-way contention from a freshly reset pointer.
        reset_dut();
        for (int i = 0; i < N; i++) begin
            exp_grant(i);
            exp_resp(i, 1'b0, 1'b0, 64'd0);
        end
        fork
            master_do(0, 32'h00, 64'hA0, 1'b1, 1, 3'b000);
            master_do(1, 32'h08, 64'hA1, 1'b1, 1, 3'b000);
            master_do(2, 32'h10, 64'hA2, 1'b1, 1, 3'b000);
            master_do(3, 32'h18, 64'hA3, 1'b1, 1, 3'b000);
        join
        idle(2);

        // Pointer wrapped back to 0: master 0 beats master 3.
        exp_grant(0); exp_resp(0, 1'b0, 1'b0, 64'd0);
        exp_grant(3); exp_resp(3, 1'b0, 1'b0, 64'd0);
        fork
            master_do(3, 32'h20, 64'hB3, 1'b1, 1, 3'b000);
            master_do(0, 32'h28, 64'hB0, 1'b1, 1, 3'b000);
        join
        idle(2);

        // 8-beat incrementing burst from master 1 while master 2 waits.
        exp_grant(1);
        for (int b = 0; b < 8; b++) exp_resp(1, 1'b0, 1'b0, 64'd0);
        exp_grant(2);
        exp_resp(2, 1'b0, 1'b0, 64'd0);
        fork
            master_do(1, 32'h00, 64'hC100, 1'b1, 8, 3'b010);
            master_do(2, 32'h60, 64'hC200, 1'b1, 1, 3'b000);
        join
        idle(2);

        // Hung slave: watchdog error after 16 stb cycles, then abort.
        exp_grant(0);
        exp_resp(0, 1'b1, 1'b0, 64'd0);
        slave_en = 1'b0;
        m_adr[0] = 32'h80; m_we[0] = 1'b1; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        cnt = 0;
        got = 1'b0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (wbs_stb_o) cnt++;
            if (wbm_err_o[0]) begin
                got = 1'b1;
                break;
            end
        end
        chk("wd_err_seen", 64'(got), 64'd1);
        chk("wd_stb_cycles", 64'(cnt), 64'd16);
        repeat (4) begin
            @(negedge clk);
            chk("abort_cyc_low", 64'(wbs_cyc_o), 64'd0);
        end
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        slave_en = 1'b1;
        idle(2);
        exp_grant(1);
        exp_resp(1, 1'b0, 1'b0, 64'd0);
        master_do(1, 32'h30, 64'hD1, 1'b1, 1, 3'b000);
        idle(2);

        // Reset in the middle of master 2's burst.
        exp_grant(2);
        for (int b = 0; b < 3; b++) exp_resp(2, 1'b0, 1'b0, 64'd0);
        m_adr[2] = 32'h00; m_we[2] = 1'b1; m_cti[2] = 3'b010;
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        @(negedge clk);
        chk("e_grant_before", 64'(grant_o), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("e_burst_ack", 64'(wbm_ack_o), 64'h4);
        end
        #1;
        wb_rst_i = 1'b1;
        @(negedge clk);
        chk("e_rst_wbs_cyc", 64'(wbs_cyc_o), 64'd0);
        chk("e_rst_grant", 64'(grant_o), 64'd0);
        #1;
        m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_cti[2] = 3'b000;
        @(posedge clk);
        #1;
        wb_rst_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_grant(i);
            exp_resp(i, 1'b0, 1'b0, 64'd0);
        end
        fork
            master_do(0, 32'h00, 64'hE0, 1'b1, 1, 3'b000);
            master_do(1, 32'h08, 64'hE1, 1'b1, 1, 3'b000);
            master_do(2, 32'h10, 64'hE2, 1'b1, 1, 3'b000);
            master_do(3, 32'h18, 64'hE3, 1'b1, 1, 3'b000);
        join
        idle(3);

        chk("grant_queue_drained", 64'(grant_q.size()), 64'd0);
        chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
